// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the RV32 datapath.
// It steps each instruction through FETCH/DECODE/EXEC/(MEM)/(WB) and drives
// every datapath control signal plus the PC write enable. It also handles
// memory wait states, interrupt entry (through BOOT) and illegal-opcode traps
// (through TRAP).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   ins, imem_ready       instruction word and instruction-memory valid
//   dmem_ready            data-memory access complete
//   int_req               level interrupt, honoured only in FETCH
//   ir_en, pc_en, INT     IR latch, PC write enable, entryPoint select
//   RegWrite, ALUSrc, op  register write, operand select, ALU op
//   MemRead, MemWrite,    data-memory controls and writeback select
//   Mem2Reg
//   isbranch, isjump      next-PC controls
//   illegal               one-cycle trap pulse
//   retired               count of completed instructions (wraps)
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      ins,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             int_req,
  output logic             ir_en,
  output logic             pc_en,
  output logic             INT,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [2:0]       op,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Mem2Reg,
  output logic             isbranch,
  output logic             isjump,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {BOOT, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_LW  = 7'h03;
  localparam logic [6:0] OP_SW  = 7'h23;
  localparam logic [6:0] OP_BEQ = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6F;

  state_t     state, nxt;
  logic [6:0] opc;
  logic [2:0] f3;
  logic       pc_w;
  logic       legal;

  assign legal = (opc == OP_R) || (opc == OP_I) || (opc == OP_LW) ||
                 (opc == OP_SW) || (opc == OP_BEQ) || (opc == OP_JAL);

  // BOOT drives pc_en, and BOOT is also the reset state. Gating with rst_n
  // keeps the PC from being written while reset is held.
  assign pc_en = pc_w & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BOOT;
      opc     <= '0;
      f3      <= '0;
      retired <= '0;
    end else begin
      state <= nxt;
      if (state == FETCH && !int_req && imem_ready) begin
        opc <= ins[6:0];
        f3  <= ins[14:12];
      end
      // BOOT and TRAP move the PC without completing an instruction.
      if (pc_w && state != BOOT && state != TRAP)
        retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    nxt      = state;
    ir_en    = 1'b0;
    pc_w     = 1'b0;
    INT      = 1'b0;
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    op       = 3'b010;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Mem2Reg  = 1'b0;
    isbranch = 1'b0;
    isjump   = 1'b0;
    illegal  = 1'b0;

    // Operand and op select are set from EXEC to the end of the instruction.
    if (state == EXEC || state == MEM || state == WB) begin
      unique case (opc)
        OP_R: begin
          ALUSrc = 1'b0;
          op     = (f3 == 3'b110) ? 3'b001 :
                   (f3 == 3'b111) ? 3'b000 : 3'b010;
        end
        OP_BEQ:  begin ALUSrc = 1'b0; op = 3'b110; end
        default: begin ALUSrc = 1'b1; op = 3'b010; end
      endcase
    end

    unique case (state)
      BOOT: begin
        INT  = 1'b1;
        pc_w = 1'b1;
        nxt  = FETCH;
      end
      FETCH: begin
        if (int_req) nxt = BOOT;
        else begin
          ir_en = 1'b1;
          if (imem_ready) nxt = DECODE;
        end
      end
      DECODE: nxt = legal ? EXEC : TRAP;
      EXEC: begin
        if (opc == OP_BEQ) begin
          isbranch = 1'b1;
          pc_w     = 1'b1;
          nxt      = FETCH;
        end else if (opc == OP_LW || opc == OP_SW) nxt = MEM;
        else nxt = WB;
      end
      MEM: begin
        if (opc == OP_LW) begin
          MemRead = 1'b1;
          Mem2Reg = 1'b1;
          if (dmem_ready) nxt = WB;
        end else begin
          // The store is held across wait cycles and retires on the ready cycle.
          MemWrite = 1'b1;
          if (dmem_ready) begin
            pc_w = 1'b1;
            nxt  = FETCH;
          end
        end
      end
      WB: begin
        RegWrite = 1'b1;
        pc_w     = 1'b1;
        Mem2Reg  = (opc == OP_LW);
        isjump   = (opc == OP_JAL);
        nxt      = FETCH;
      end
      TRAP: begin
        illegal = 1'b1;
        INT     = 1'b1;
        pc_w    = 1'b1;
        nxt     = FETCH;
      end
      default: nxt = BOOT;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  localparam int CW = 3;  // small counter so the wrap is exercised

  logic clk = 0, rst_n = 0;
  logic [31:0] ins = '0;
  logic imem_ready = 0, dmem_ready = 0, int_req = 0;
  logic ir_en, pc_en, INT, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg;
  logic isbranch, isjump, illegal;
  logic [2:0] op;
  logic [CW-1:0] retired;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ins(ins), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .int_req(int_req), .ir_en(ir_en), .pc_en(pc_en),
    .INT(INT), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .op(op), .MemRead(MemRead),
    .MemWrite(MemWrite), .Mem2Reg(Mem2Reg), .isbranch(isbranch), .isjump(isjump),
    .illegal(illegal), .retired(retired));

  always #5 clk = ~clk;

  typedef struct packed {
    logic ir, pc, intr, rw, as;
    logic [2:0] op;
    logic mr, mw, m2r, br, j, ill;
  } out_t;

  typedef struct {
    string   name;
    logic [31:0] ins;
    logic    imr, dmr, irq;
    out_t    exp;
    logic [CW-1:0] ret;
  } cyc_t;

  typedef struct {
    logic [31:0] ins;
    int waits;
    int stalls;
  } vec_t;

  cyc_t q[$];
  logic [CW-1:0] ret_model = '0;
  int n_cmp = 0, n_bad = 0;
  out_t got;

  assign got = '{ir: ir_en, pc: pc_en, intr: INT, rw: RegWrite, as: ALUSrc, op: op,
                 mr: MemRead, mw: MemWrite, m2r: Mem2Reg, br: isbranch, j: isjump,
                 ill: illegal};

  function automatic out_t idle();
    out_t o = '0;
    o.op = 3'b010;
    return o;
  endfunction

  task automatic push(string nm, logic [31:0] i, logic imr, logic dmr, logic irq,
                      out_t o, logic inc);
    cyc_t c;
    c.name = nm; c.ins = i; c.imr = imr; c.dmr = dmr; c.irq = irq;
    c.exp = o; c.ret = ret_model;
    q.push_back(c);
    if (inc) ret_model = ret_model + 1'b1;
  endtask

  // Expected per-cycle sequence of one instruction, written from the
  // instruction-class behaviour (FETCH, DECODE, EXEC, MEM waits, WB).
  task automatic gen_instr(logic [31:0] i, int waits, int stalls, logic irq_mem);
    logic [6:0] opc;
    logic [2:0] f3;
    out_t o, base;
    opc = i[6:0];
    f3  = i[14:12];
    o = idle(); o.ir = 1;
    for (int s = 0; s < stalls; s++) push("fetch_stall", i, 0, 0, 0, o, 0);
    push("fetch", i, 1, 0, 0, o, 0);
    push("decode", i, 1, 0, 0, idle(), 0);
    if (!(opc inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F})) begin
      o = idle(); o.intr = 1; o.pc = 1; o.ill = 1;
      push("trap", i, 1, 0, 0, o, 0);
      return;
    end
    base = idle();
    case (opc)
      7'h33:   base.op = (f3 == 3'b110) ? 3'b001 : (f3 == 3'b111) ? 3'b000 : 3'b010;
      7'h63:   base.op = 3'b110;
      default: base.as = 1;
    endcase
    o = base;
    if (opc == 7'h63) begin
      o.br = 1; o.pc = 1;
      push("exec_beq", i, 1, 0, 0, o, 1);
      return;
    end
    push("exec", i, 1, 0, 0, o, 0);
    if (opc == 7'h03 || opc == 7'h23) begin
      for (int k = 0; k <= waits; k++) begin
        o = base;
        if (opc == 7'h03) begin o.mr = 1; o.m2r = 1; end
        else begin o.mw = 1; o.pc = (k == waits); end
        push("mem", i, 1, (k == waits), irq_mem, o, (opc == 7'h23) && (k == waits));
      end
      if (opc == 7'h23) return;
    end
    o = base; o.rw = 1; o.pc = 1;
    o.m2r = (opc == 7'h03); o.j = (opc == 7'h6F);
    push("wb", i, 1, 0, 0, o, 1);
  endtask

  task automatic push_boot();
    out_t o = idle();
    o.intr = 1; o.pc = 1;
    push("boot", '0, 1, 0, 0, o, 0);
  endtask

  // Called at a negedge: drive each queued cycle, check, and advance.
  task automatic drain();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      ins = c.ins; imem_ready = c.imr; dmem_ready = c.dmr; int_req = c.irq;
      #1;
      n_cmp++;
      if (got !== c.exp || retired !== c.ret) begin
        n_bad++;
        $display("FAIL %s t=%0t outs got %b exp %b retired got %0d exp %0d",
                 c.name, $time, got, c.exp, retired, c.ret);
      end
      @(negedge clk);
    end
  endtask

  task automatic check_reset(string nm);
    out_t e = idle();
    e.intr = 1;
    n_cmp++;
    if (got !== e || retired !== '0) begin
      n_bad++;
      $display("FAIL %s outs got %b exp %b retired got %0d exp 0", nm, got, e, retired);
    end
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{32'h002081B3, 0, 0};  // add
    vecs[1]  = '{32'h0020E1B3, 0, 0};  // or
    vecs[2]  = '{32'h0020F1B3, 0, 0};  // and
    vecs[3]  = '{32'h0020C1B3, 0, 0};  // xor funct3 -> add op
    vecs[4]  = '{32'h00108093, 0, 0};  // addi
    vecs[5]  = '{32'h0000A183, 3, 0};  // lw, 3 wait cycles
    vecs[6]  = '{32'h0020A023, 0, 0};  // sw, no wait
    vecs[7]  = '{32'h0020A023, 2, 0};  // sw, 2 wait cycles
    vecs[8]  = '{32'h00208463, 0, 0};  // beq
    vecs[9]  = '{32'h0000006F, 0, 0};  // jal
    vecs[10] = '{32'h0000007F, 0, 0};  // illegal
    vecs[11] = '{32'h0000A183, 0, 2};  // lw after fetch stall

    imem_ready = 1;
    repeat (2) @(negedge clk);
    #1 check_reset("reset_hold");
    @(negedge clk);
    rst_n = 1;
    push_boot();
    foreach (vecs[v]) gen_instr(vecs[v].ins, vecs[v].waits, vecs[v].stalls, 0);
    drain();

    // Interrupt raised during a store wait: the store finishes, then the
    // following FETCH diverts to BOOT without fetching.
    gen_instr(32'h0020A023, 2, 0, 1);
    push("fetch_int", 32'h002081B3, 1, 0, 1, idle(), 0);
    push_boot();
    gen_instr(32'h002081B3, 0, 0, 0);
    drain();

    // Reset during a store wait drops MemWrite immediately.
    gen_instr(32'h0020A023, 6, 0, 0);
    while (q.size() > 6) begin
      cyc_t c;
      c = q.pop_back();
    end
    drain();
    rst_n = 0;
    #1 check_reset("reset_mid_sw");
    @(negedge clk);
    rst_n = 1;
    ret_model = '0;
    push_boot();
    gen_instr(32'h002081B3, 0, 0, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
